// File: rtl/stopwatch_pkg.sv
// Shared types for the BCD lap stopwatch: control state encoding and BCD digit type.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade: increments on en_i, wraps 9 -> 0, flags when it sits at nine
// so the parent can build the carry chain.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output bcd_t digit_o,
  output logic at_nine_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (en_i) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o   = digit_q;
  assign at_nine_o = (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_lap_stopwatch.sv
// N-digit BCD stopwatch with run/stop/clear control, a lap-capture FIFO
// (first-word fall-through) and a sticky rollover flag.
module bcd_lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_stop_i,
  input  logic                           lap_clear_i,
  input  logic                           lap_read_i,
  output logic [4*DIGITS-1:0]            digits_o,
  output logic                           running_o,
  output logic [4*DIGITS-1:0]            lap_data_o,
  output logic                           lap_valid_o,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count_o,
  output logic                           lap_full_o,
  output logic                           overflow_o,
  output logic [1:0]                     state_o
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(LAP_DEPTH);

  // Handshake: start_stop_i, lap_clear_i and lap_read_i are single-cycle
  // strobes with no ready; each is acted on at the rising edge where it is high.
  // start_stop_i outranks lap_clear_i when both arrive together.

  sw_state_e state_q;
  logic      running_q;

  logic lap_clear_eff;
  logic clear_all;
  logic push_req;
  logic pop;
  logic push;
  logic tick;

  assign lap_clear_eff = lap_clear_i & ~start_stop_i;
  assign clear_all     = (state_q == STOP) & lap_clear_eff;
  assign push_req      = (state_q == RUN) & lap_clear_eff;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop_i) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop_i) begin
            state_q   <= STOP;
            running_q <= 1'b0;
          end
        end
        STOP: begin
          if (start_stop_i) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (lap_clear_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- prescaler ----------------
  // Held while stopped so a resume continues the partial period exactly.
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  assign tick = (state_q == RUN) & (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    if (clear_all) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------- digit chain ----------------
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] at_nine;
  logic [DW-1:0]     digits;

  assign carry[0] = tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (carry[g]),
      .clr_i     (clear_all),
      .digit_o   (digits[4*g +: 4]),
      .at_nine_o (at_nine[g])
    );
    assign carry[g+1] = carry[g] & at_nine[g];
  end

  // carry out of the top digit means every digit was nine on this tick
  logic overflow_q;
  logic overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (clear_all) begin
      overflow_d = 1'b0;
    end else if (carry[DIGITS]) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // ---------------- lap FIFO ----------------
  logic [DW-1:0] mem_q [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop        = lap_read_i & ~fifo_empty & ~clear_all;
  // a full FIFO still accepts a push when the head is popped in the same cycle
  assign push       = push_req & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_all) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= digits;
    end
  end

  // ---------------- outputs ----------------
  assign digits_o    = digits;
  assign running_o   = running_q;
  assign lap_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign lap_valid_o = ~fifo_empty;
  assign lap_count_o = count_q;
  assign lap_full_o  = fifo_full;
  assign overflow_o  = overflow_q;
  assign state_o     = state_q;

endmodule

// File: doc/bcd_lap_stopwatch.md
# bcd_lap_stopwatch

Parametrised N-digit BCD stopwatch core with run/stop/clear control, lap capture into an on-chip FIFO, and rollover detection. It sits between the debounced button pulses and the seven-segment driver path: its digit bus feeds per-digit BCD-to-seven-segment decoders, and its lap FIFO is read out by a display mux or a processor. It replaces the fixed four-digit, 10 ms counter chain with a generic one.

## Interface
- DIGITS, 4, number of BCD digits (2..8); digit 0 is least significant
- TICK_DIV, 1000000, Clock cycles per count increment (10 ms at 100 MHz); must be ≥ 2
- LAP_DEPTH, 4, lap FIFO entries (power of two, ≥ 2)
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- StartStop  in  1  one-cycle pulse (already debounced): start, stop or resume
- LapClear  in  1  one-cycle pulse: lap capture while running, clear while stopped
- LapRead  in  1  one-cycle pulse: pop the FIFO head
- Digits  out  4*DIGITS  live count, digit i at [4i+3:4i]
- Running  out  1  high in RUN
- LapData  out  4*DIGITS  FIFO head (first-word fall-through); zero when empty
- LapValid  out  1  FIFO not empty
- LapCount  out  $clog2(LAP_DEPTH+1)  entries held
- LapFull  out  1  FIFO full
- Overflow  out  1  sticky: count wrapped past all-nines

## Operation
- States: IDLE (count zero), RUN, STOP. Reset → IDLE; every output resets to 0.
- IDLE: StartStop → RUN. LapClear ignored.
- RUN: StartStop → STOP. LapClear pushes current Digits into FIFO.
- STOP: StartStop → RUN (resume, no clear). LapClear → IDLE: zeroes Digits, prescaler, Overflow, and flushes the FIFO.
- StartStop and LapClear in the same cycle: StartStop wins, LapClear dropped.
- Prescaler runs only in RUN, counts 0..TICK_DIV-1; tick = prescaler at TICK_DIV-1 while in RUN. Held (not cleared) in STOP, so resume is exact; cleared on IDLE entry.
- On tick, digit 0 increments; digit i increments when tick and digits 0..i-1 all equal 9. A digit at 9 that increments becomes 0.
- All digits 9 plus tick → all zero, Overflow set; it stays set until clear or Reset. Counting continues.
- Lap push captures the pre-increment value when it coincides with a tick.
- Push while full: entry discarded, FIFO unchanged, LapFull stays high.
- LapRead while empty: ignored. Push and pop in the same cycle (non-empty): both occur, LapCount unchanged. Push and pop while empty: push only.
- Reset mid-operation: immediate return to IDLE with FIFO empty, regardless of state.

## Timing
- Control pulse sampled at edge t; Running, state and FIFO pointers reflect it after edge t.
- First increment TICK_DIV cycles after the RUN-entry edge; subsequent increments every TICK_DIV RUN cycles.
- Digits, LapData, LapValid, LapCount, LapFull and Overflow are registered or decoded only from registers; there are no combinational paths from inputs.
- LapData/LapValid are valid the cycle after the push edge.
- Clear-to-zero takes effect at the LapClear edge in STOP.

## Structure
- Shared package stopwatch_pkg: state enum (IDLE, RUN, STOP), BCD_MAX = 4'd9, BCD digit type.
- Sub-module bcd_digit_counter: one 4-bit digit with enable, synchronous clear, async Reset, and an at-nine flag; generated DIGITS times, with the carry chain built from the at-nine flags.
- Lap FIFO and prescaler are inline in the top module.

## Test plan
- TICK_DIV=4, DIGITS=2: Reset, StartStop, wait 40 cycles → Digits = 8'h10, Running=1.
- Run to 8'h99, then 4 more cycles → Digits = 8'h00, Overflow=1; LapClear in STOP → Overflow=0, Digits=0.
- Stop at 8'h05 for 50 cycles, resume → next increment exactly (4 − elapsed prescaler) cycles later, reaching 8'h06, with no lost or extra tick.
- LAP_DEPTH=4: five LapClear pulses in RUN at 8'h01..8'h05 → LapFull=1, LapCount=4; four reads return 01, 02, 03, 04; LapValid then 0.
- StartStop and LapClear in the same cycle during RUN → STOP entered, no FIFO push; simultaneous LapRead and push with LapCount=2 → LapCount stays 2.
- Assert Reset in RUN with 3 laps stored → all outputs 0 at once; a following StartStop starts counting from 0.
